// File: rtl/key_recorder.sv
// key_recorder: records live key/octave activity into a buffer and replays it.
// Define KEY_RECORDER_LOOP_EN to loop playback until replay is pulsed again.
module key_recorder #(
  parameter int DEPTH    = 64,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 500000
) (
  input  logic                   sys_CLK,
  input  logic                   sys_RST_n,
  input  logic                   rec,
  input  logic                   replay,
  input  logic [6:0]             key_in,
  input  logic                   high_in,
  input  logic                   low_in,
  output logic [6:0]             key_out,
  output logic                   high_out,
  output logic                   low_out,
  output logic                   playing,
  output logic                   rec_full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = 9 + DUR_W;
`ifdef KEY_RECORDER_LOOP_EN
  localparam bit LoopEn = 1'b1;
`else
  localparam bit LoopEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE, REC, PLAY_LOAD, PLAY_HOLD
  } state_e;

  state_e           state_q;
  logic             rec_q;
  logic             replay_q;
  logic [TW-1:0]    tdiv_q;
  logic [8:0]       pass_q;
  logic [8:0]       ent_q;
  logic [8:0]       held_q;
  logic [DUR_W-1:0] dur_q;
  logic [DUR_W-1:0] rem_q;
  logic [CW-1:0]    wr_ptr_q;
  logic [CW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             playing_q;
  logic             full_q;
  logic [EW-1:0]    mem [DEPTH];

  logic          tick;
  logic          rec_rise;
  logic          rec_fall;
  logic          replay_rise;
  logic [8:0]    sample;
  logic          same;
  logic          dur_max;
  logic          has_dur;
  logic          at_end;
  logic          rec_cut;
  logic          mem_we;
  logic [CW-1:0] wr_nxt;
  logic [CW-1:0] rd_nxt;

  assign tick        = (tdiv_q == TW'(TICK_DIV - 1));
  assign rec_rise    = rec & ~rec_q;
  assign rec_fall    = ~rec & rec_q;
  assign replay_rise = replay & ~replay_q;
  assign sample      = {key_in, high_in, low_in};
  assign same        = (sample == held_q);
  assign dur_max     = &dur_q;
  assign has_dur     = |dur_q;
  assign at_end      = (wr_ptr_q == CW'(DEPTH));
  assign wr_nxt      = wr_ptr_q + CW'(1);
  assign rd_nxt      = rd_ptr_q + CW'(1);

  // The held run closes on rec fall, a new key, or a saturated duration.
  assign rec_cut = rec_fall | (tick & ~(same & ~dur_max));
  assign mem_we  = (state_q == REC) & rec_cut & has_dur & ~at_end;

  always_ff @(posedge sys_CLK) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {held_q, dur_q};
  end

  always_ff @(posedge sys_CLK or negedge sys_RST_n) begin
    if (!sys_RST_n) begin
      state_q   <= IDLE;
      rec_q     <= 1'b0;
      replay_q  <= 1'b0;
      tdiv_q    <= '0;
      pass_q    <= '0;
      ent_q     <= '0;
      held_q    <= '0;
      dur_q     <= '0;
      rem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      playing_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      rec_q    <= rec;
      replay_q <= replay;
      pass_q   <= sample;
      tdiv_q   <= tick ? '0 : tdiv_q + TW'(1);
      if (rec_rise) begin
        state_q   <= REC;
        wr_ptr_q  <= '0;
        count_q   <= '0;
        full_q    <= 1'b0;
        held_q    <= sample;
        dur_q     <= '0;
        playing_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (replay_rise && !rec && count_q != '0) begin
              state_q   <= PLAY_LOAD;
              rd_ptr_q  <= '0;
              ent_q     <= '0;
              playing_q <= 1'b1;
            end
          end
          REC: begin
            if (rec_cut) begin
              if (mem_we) begin
                wr_ptr_q <= wr_nxt;
                count_q  <= wr_nxt;
              end
              if (has_dur && at_end) begin
                full_q  <= 1'b1;
                state_q <= IDLE;
              end
              if (rec_fall) state_q <= IDLE;
              held_q <= sample;
              dur_q  <= DUR_W'(1);
            end else if (tick) begin
              dur_q <= dur_q + DUR_W'(1);
            end
          end
          PLAY_LOAD: begin
            if (LoopEn && replay_rise) begin
              state_q   <= IDLE;
              playing_q <= 1'b0;
            end else begin
              {ent_q, rem_q} <= mem[rd_ptr_q[AW-1:0]];
              state_q        <= PLAY_HOLD;
            end
          end
          PLAY_HOLD: begin
            if (LoopEn && replay_rise) begin
              state_q   <= IDLE;
              playing_q <= 1'b0;
            end else if (tick) begin
              if (rem_q < DUR_W'(2)) begin
                if (rd_nxt != count_q) begin
                  rd_ptr_q <= rd_nxt;
                  state_q  <= PLAY_LOAD;
                end else if (LoopEn) begin
                  rd_ptr_q <= '0;
                  state_q  <= PLAY_LOAD;
                end else begin
                  state_q   <= IDLE;
                  playing_q <= 1'b0;
                end
              end else begin
                rem_q <= rem_q - DUR_W'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign {key_out, high_out, low_out} = playing_q ? ent_q : pass_q;
  assign playing  = playing_q;
  assign rec_full = full_q;
  assign count    = count_q;

endmodule

// File: tb/tb_key_recorder.sv
// tb_key_recorder: random record/replay sessions against a run-length model.
// Also covers reset, passthrough, saturation, overflow and abort cases.
module tb_key_recorder;

  localparam int DEPTH = 4;
  localparam int DUR_W = 4;
  localparam int TD    = 4;
  localparam int DMAX  = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rec = 1'b0;
  logic       replay = 1'b0;
  logic [6:0] key_in = '0;
  logic       high_in = 1'b0;
  logic       low_in = 1'b0;
  logic [6:0] key_out;
  logic       high_out;
  logic       low_out;
  logic       playing;
  logic       rec_full;
  logic [2:0] count;
  logic [8:0] out;

  int n_chk = 0;
  int n_pass = 0;
  int edges;

  typedef struct {
    logic [8:0] v;
    int         dur;
  } ent_t;

  logic [8:0] smp[$];
  ent_t       mdl[$];
  bit         exp_full;
  int         n_chunks;

  key_recorder #(
    .DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TD)
  ) dut (
    .sys_CLK(clk), .sys_RST_n(rst_n),
    .rec(rec), .replay(replay),
    .key_in(key_in), .high_in(high_in), .low_in(low_in),
    .key_out(key_out), .high_out(high_out), .low_out(low_out),
    .playing(playing), .rec_full(rec_full), .count(count)
  );

  assign out = {key_out, high_out, low_out};

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else edges <= edges + 1;
  end

  initial begin
    #600000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(string tag, int unsigned got, int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after a tick edge.
  task automatic to_tick();
    do step(); while (edges % TD != 0);
  endtask

  task automatic set_in(input logic [8:0] v);
    {key_in, high_in, low_in} = v;
  endtask

  // Runs of equal samples, each split into pieces of at most DMAX ticks.
  function automatic void build();
    ent_t ch[$];
    int i;
    int j;
    int len;
    int d;
    i = 0;
    while (i < smp.size()) begin
      j = i;
      while (j < smp.size() && smp[j] == smp[i]) j++;
      len = j - i;
      while (len > 0) begin
        d = (len > DMAX) ? DMAX : len;
        ch.push_back('{smp[i], d});
        len -= d;
      end
      i = j;
    end
    n_chunks = ch.size();
    exp_full = (n_chunks > DEPTH);
    mdl.delete();
    for (int k = 0; k < n_chunks && k < DEPTH; k++) mdl.push_back(ch[k]);
  endfunction

  task automatic rec_samples();
    to_tick();
    set_in(smp[0]);
    rec = 1'b1;
    step();
    for (int i = 0; i < smp.size(); i++) begin
      set_in(smp[i]);
      to_tick();
    end
  endtask

  task automatic rec_drop();
    rec = 1'b0;
    set_in(9'($urandom));
    step();
    step();
  endtask

  task automatic play_check(string tag);
    logic [8:0] live;
    int seen;
    bit ok;
    live = 9'($urandom);
    set_in(live);
    replay = 1'b1;
    step();
    check({tag, "_playing"}, playing, 1);
    replay = 1'b0;
    step();
    for (int i = 0; i < mdl.size(); i++) begin
      check($sformatf("%s_ent%0d", tag, i), out, mdl[i].v);
      seen = 0;
      ok = 1'b1;
      while (seen < mdl[i].dur) begin
        step();
        if (edges % TD == 0) seen++;
        if (seen < mdl[i].dur && (out !== mdl[i].v || playing !== 1'b1))
          ok = 1'b0;
      end
      check($sformatf("%s_hold%0d", tag, i), ok, 1);
      if (i + 1 < mdl.size()) step();
    end
`ifdef KEY_RECORDER_LOOP_EN
    step();
    check({tag, "_wrap"}, out, mdl[0].v);
    replay = 1'b1;
    step();
    replay = 1'b0;
    check({tag, "_loop_stop"}, playing, 0);
`else
    check({tag, "_end_playing"}, playing, 0);
    check({tag, "_end_pass"}, out, live);
`endif
    step();
  endtask

  task automatic gen_random();
    logic [8:0] a[3];
    logic [8:0] v;
    int nr;
    int len;
    smp.delete();
    for (int k = 0; k < 3; k++) a[k] = 9'($urandom);
    nr = $urandom_range(1, 6);
    for (int r = 0; r < nr; r++) begin
      v = a[$urandom_range(0, 2)];
      len = $urandom_range(1, 18);
      repeat (len) smp.push_back(v);
    end
    build();
    if (n_chunks == DEPTH + 1) begin
      smp.push_back(smp[smp.size() - 1] ^ 9'h100);
      build();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_playing", playing, 0);
    check("rst_full", rec_full, 0);
    check("rst_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    replay = 1'b1;
    step();
    check("empty_play", playing, 0);
    replay = 1'b0;
    step();
    check("empty_play2", playing, 0);

    set_in({7'b0000001, 1'b1, 1'b0});
    step();
    check("pass", out, {7'b0000001, 1'b1, 1'b0});
    set_in({7'b0100000, 1'b0, 1'b1});
    step();
    check("pass2", out, {7'b0100000, 1'b0, 1'b1});

    smp.delete();
    repeat (3) smp.push_back({7'b0000001, 2'b00});
    repeat (2) smp.push_back({7'b0000010, 2'b00});
    build();
    rec_samples();
    rec_drop();
    check("dir_count", count, 2);
    check("dir_full", rec_full, 0);
    play_check("dir");

    smp.delete();
    repeat (20) smp.push_back({7'b0000100, 2'b00});
    build();
    rec_samples();
    rec_drop();
    check("sat_count", count, 2);
    play_check("sat");

    smp.delete();
    for (int k = 0; k < 5; k++) smp.push_back({7'(1 << k), 2'b00});
    smp.push_back(9'h000);
    build();
    rec_samples();
    check("ovf_full", rec_full, 1);
    check("ovf_count", count, 4);
    set_in({7'b1000000, 2'b11});
    to_tick();
    to_tick();
    check("ovf_idle_count", count, 4);
    rec_drop();
    check("ovf_full_after", rec_full, 1);
    play_check("ovf");

    replay = 1'b1;
    step();
    replay = 1'b0;
    repeat (3) step();
    rec = 1'b1;
    step();
    check("abort_playing", playing, 0);
    check("abort_count", count, 0);
    rec = 1'b0;
    repeat (2) step();

    smp.delete();
    repeat (4) smp.push_back({7'b0001000, 2'b10});
    build();
    rec_samples();
    rec_drop();
    check("pre_rst_count", count, 1);
    replay = 1'b1;
    step();
    replay = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", out, 0);
    check("mid_rst_playing", playing, 0);
    check("mid_rst_count", count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    replay = 1'b1;
    step();
    replay = 1'b0;
    check("post_rst_play", playing, 0);
    step();

    for (int s = 0; s < 8; s++) begin
      gen_random();
      rec_samples();
      rec_drop();
      check($sformatf("rnd%0d_count", s), count, mdl.size());
      check($sformatf("rnd%0d_full", s), rec_full, exp_full);
      repeat ($urandom_range(0, 5)) step();
      play_check($sformatf("rnd%0d", s));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
